// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches to instruction memory, buffers the
// returned words with their PCs in a small FIFO and hands them to the core over valid/ready.
// A redirect from the core flushes the buffer and turns every in-flight fetch into a stale one
// whose response is silently dropped.
//
// Ports:
//   i_Clock, i_Reset                      clock (rising edge), async active-high reset
//   o_Mem_Req_Valid/Addr, i_Mem_Req_Ready  fetch request channel (valid/ready)
//   i_Mem_Resp_Valid/Data                  in-order response channel, one per accepted request
//   o_Instruction_Valid/_Addr, o_Instruction, i_Instruction_Ready  core channel (valid/ready)
//   i_Redirect_Valid/Addr                  redirect target from the core; addr bits [1:0] ignored
module instruction_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  output logic            o_Mem_Req_Valid,
  output logic [XLEN-1:0] o_Mem_Req_Addr,
  input  logic            i_Mem_Req_Ready,
  input  logic            i_Mem_Resp_Valid,
  input  logic [XLEN-1:0] i_Mem_Resp_Data,
  output logic            o_Instruction_Valid,
  output logic [XLEN-1:0] o_Instruction,
  output logic [XLEN-1:0] o_Instruction_Addr,
  input  logic            i_Instruction_Ready,
  input  logic            i_Redirect_Valid,
  input  logic [XLEN-1:0] i_Redirect_Addr
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] fill_ptr_q, fill_ptr_d;
  // Allocated entries (filled or still awaiting their live response).
  logic [CntW-1:0] alloc_cnt_q, alloc_cnt_d;
  // All outstanding requests, live and stale.
  logic [CntW-1:0] inflight_q, inflight_d;
  // Stale outstanding requests whose responses must be discarded.
  logic [CntW-1:0] drop_q, drop_d;

  logic            entry_filled_q [FIFO_DEPTH];
  logic [XLEN-1:0] entry_addr_q   [FIFO_DEPTH];
  logic [XLEN-1:0] entry_data_q   [FIFO_DEPTH];

  logic [CntW:0] occupancy;
  logic          req_valid, req_fire;
  logic          resp_ok, resp_drop, resp_fill;
  logic          instr_valid, pop;

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_Redirect_Addr[1:0];

  // Stale requests occupy no entry but still reserve space, so the cap covers them too.
  assign occupancy = {1'b0, alloc_cnt_q} + {1'b0, drop_q};
  assign req_valid = !i_Reset && (occupancy < DepthCnt);
  assign req_fire  = req_valid && i_Mem_Req_Ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = i_Mem_Resp_Valid && (inflight_q != '0);
  assign resp_drop = resp_ok && (drop_q != '0);
  assign resp_fill = resp_ok && (drop_q == '0);

  assign instr_valid = !i_Reset && entry_filled_q[rd_ptr_q];
  assign pop         = instr_valid && i_Instruction_Ready;

  assign o_Mem_Req_Valid     = req_valid;
  assign o_Mem_Req_Addr      = i_Reset ? '0 : pc_q;
  assign o_Instruction_Valid = instr_valid;
  assign o_Instruction       = instr_valid ? entry_data_q[rd_ptr_q] : '0;
  assign o_Instruction_Addr  = instr_valid ? entry_addr_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q + PtrW'(pop);
    wr_ptr_d    = wr_ptr_q + PtrW'(req_fire);
    fill_ptr_d  = fill_ptr_q + PtrW'(resp_fill);
    alloc_cnt_d = alloc_cnt_q + CntW'(req_fire) - CntW'(pop);
    inflight_d  = inflight_q + CntW'(req_fire) - CntW'(resp_ok);
    drop_d      = drop_q - CntW'(resp_drop);

    if (req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end

    if (i_Redirect_Valid) begin
      pc_d        = {i_Redirect_Addr[XLEN-1:2], 2'b00};
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      fill_ptr_d  = '0;
      alloc_cnt_d = '0;
      // Everything still outstanding after this edge, including a request accepted now, is stale.
      drop_d      = inflight_d;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fill_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      inflight_q  <= '0;
      drop_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
    end
  end

  // Allocation, fill and pop never target the same slot in one cycle: allocation needs a free
  // slot, fill needs an allocated unfilled slot, pop needs a filled one.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        entry_filled_q[i] <= 1'b0;
        entry_addr_q[i]   <= '0;
        entry_data_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (i_Redirect_Valid) begin
          entry_filled_q[i] <= 1'b0;
        end else begin
          if (req_fire && (wr_ptr_q == PtrW'(i))) begin
            entry_filled_q[i] <= 1'b0;
            entry_addr_q[i]   <= pc_q;
          end
          if (resp_fill && (fill_ptr_q == PtrW'(i))) begin
            entry_filled_q[i] <= 1'b1;
            entry_data_q[i]   <= i_Mem_Resp_Data;
          end
          if (pop && (rd_ptr_q == PtrW'(i))) begin
            entry_filled_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  resp_has_request_a: assert property (@(posedge i_Clock) disable iff (i_Reset)
    i_Mem_Resp_Valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a fixed-latency memory model answers every
// accepted fetch with (addr ^ KEY); expected PCs and words are hand-derived per scenario.
module tb_instruction_fetch_unit;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, w_req_valid;
  logic [31:0] req_addr, w_req_addr;
  logic        mem_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid, w_inst_valid;
  logic [31:0] inst, inst_addr, w_inst, w_inst_addr;
  logic        core_ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_addr = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  always #5 clk = ~clk;

  instruction_fetch_unit #(.XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .o_Mem_Req_Valid(req_valid), .o_Mem_Req_Addr(req_addr), .i_Mem_Req_Ready(mem_ready),
    .i_Mem_Resp_Valid(resp_valid), .i_Mem_Resp_Data(resp_data),
    .o_Instruction_Valid(inst_valid), .o_Instruction(inst), .o_Instruction_Addr(inst_addr),
    .i_Instruction_Ready(core_ready),
    .i_Redirect_Valid(redir), .i_Redirect_Addr(redir_addr)
  );

  // Wrap-around instance: memory always ready, never answers (it stalls after 4 requests).
  instruction_fetch_unit #(.XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_Clock(clk), .i_Reset(rst),
    .o_Mem_Req_Valid(w_req_valid), .o_Mem_Req_Addr(w_req_addr), .i_Mem_Req_Ready(1'b1),
    .i_Mem_Resp_Valid(1'b0), .i_Mem_Resp_Data(32'h0),
    .o_Instruction_Valid(w_inst_valid), .o_Instruction(w_inst), .o_Instruction_Addr(w_inst_addr),
    .i_Instruction_Ready(1'b1),
    .i_Redirect_Valid(1'b0), .i_Redirect_Addr(32'h0)
  );

  // Memory model: accept at end of cycle k, answer during cycle k+lat.
  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      n_acc = 0;
    end else if (req_valid && mem_ready) begin
      q_addr.push_back(req_addr);
      q_due.push_back(cyc + lat);
      n_acc++;
    end
    cyc++;
    #1;
    if (!rst && q_addr.size() > 0 && q_due[0] <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = q_addr[0] ^ KEY;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    redir = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Waits up to a bounded number of cycles for o_Instruction_Valid; a timeout is a failure.
  task automatic wait_inst(input string tag);
    int k;
    for (k = 0; k < 20 && !inst_valid; k++) step();
    check_eq({tag, "_valid"}, {31'b0, inst_valid}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, streaming, first-valid latency; 5: wrap-around instance
    lat = 1; mem_ready = 1'b1; core_ready = 1'b1;
    step();
    check_eq("rst_req_valid", {31'b0, req_valid}, 32'h0);
    check_eq("rst_req_addr", req_addr, 32'h0);
    check_eq("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_addr", inst_addr, 32'h0);
    check_eq("rst_wrap_addr", w_req_addr, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("t1_c0_req_valid", {31'b0, req_valid}, 32'h1);
    check_eq("t1_c0_req_addr", req_addr, 32'h0);
    check_eq("t1_c0_inst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("t5_wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
    check_eq("t5_wrap_valid0", {31'b0, w_req_valid}, 32'h1);
    step();
    check_eq("t1_c1_inst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("t5_wrap_addr1", w_req_addr, 32'h0000_0000);
    step();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_valid%0d", i), {31'b0, inst_valid}, 32'h1);
      check_eq($sformatf("t1_addr%0d", i), inst_addr, 32'(4 * i));
      check_eq($sformatf("t1_data%0d", i), inst, 32'(4 * i) ^ KEY);
      step();
    end

    // 2: core stalled -> exactly 4 fetches, then in-order drain and resume at 0x10
    lat = 1; mem_ready = 1'b1; core_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check_eq("t2_n_acc", 32'(n_acc), 32'd4);
    check_eq("t2_req_valid_cap", {31'b0, req_valid}, 32'h0);
    check_eq("t2_head_addr", inst_addr, 32'h0);
    check_eq("t2_head_stable", inst, 32'h0 ^ KEY);
    core_ready = 1'b1;
    step();
    check_eq("t2_req_resume_valid", {31'b0, req_valid}, 32'h1);
    check_eq("t2_req_resume_addr", req_addr, 32'h10);
    check_eq("t2_addr4", inst_addr, 32'h4);
    step();
    check_eq("t2_addr8", inst_addr, 32'h8);
    step();
    check_eq("t2_addrC", inst_addr, 32'hC);
    check_eq("t2_dataC", inst, 32'hC ^ KEY);
    step();
    check_eq("t2_addr10", inst_addr, 32'h10);

    // 3: latency 3, two in flight, redirect to 0x102 -> both dropped, restart at 0x100
    lat = 3; mem_ready = 1'b1; core_ready = 1'b1;
    do_reset();
    step();
    step();
    mem_ready = 1'b0; redir = 1'b1; redir_addr = 32'h102;
    step();
    redir = 1'b0; mem_ready = 1'b1;
    check_eq("t3_req_addr", req_addr, 32'h100);
    check_eq("t3_req_valid", {31'b0, req_valid}, 32'h1);
    check_eq("t3_no_stale", {31'b0, inst_valid}, 32'h0);
    wait_inst("t3_first");
    check_eq("t3_first_addr", inst_addr, 32'h100);
    check_eq("t3_first_data", inst, 32'h100 ^ KEY);
    step();
    wait_inst("t3_second");
    check_eq("t3_second_addr", inst_addr, 32'h104);

    // 4: memory stalls 5 cycles -> request held stable
    lat = 1; mem_ready = 1'b1; core_ready = 1'b1;
    do_reset();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_hold_valid%0d", i), {31'b0, req_valid}, 32'h1);
      check_eq($sformatf("t4_hold_addr%0d", i), req_addr, 32'h8);
      step();
    end
    mem_ready = 1'b1;
    step();
    check_eq("t4_advance_addr", req_addr, 32'hC);

    // 6: reset with 3 buffered + 1 in flight
    lat = 2; mem_ready = 1'b1; core_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check_eq("t6_n_acc", 32'(n_acc), 32'd4);
    check_eq("t6_buffered_valid", {31'b0, inst_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_req_valid", {31'b0, req_valid}, 32'h0);
    check_eq("t6_rst_req_addr", req_addr, 32'h0);
    check_eq("t6_rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check_eq("t6_rst_inst", inst, 32'h0);
    check_eq("t6_rst_inst_addr", inst_addr, 32'h0);
    step();
    step();
    rst = 1'b0; core_ready = 1'b1;
    #1;
    check_eq("t6_restart_addr", req_addr, 32'h0);
    wait_inst("t6_first");
    check_eq("t6_first_addr", inst_addr, 32'h0);
    check_eq("t6_first_data", inst, 32'h0 ^ KEY);
    step();
    wait_inst("t6_second");
    check_eq("t6_second_addr", inst_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
